// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch front end with PC, one-outstanding I-cache request and decode buffer
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] cpu_req_addr,
    output logic        cpu_req_valid,
    input  logic [31:0] cpu_req_data,
    input  logic        cpu_req_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    input  logic        id_ready
);
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     tgt_q, tgt_d;
    logic            valid_q, valid_d;
    logic [31:0]     pc_mem_q   [BUF_DEPTH];
    logic [31:0]     inst_mem_q [BUF_DEPTH];
    logic [PW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   occ_q, occ_d;

    logic        resp, push, pop, slot_ok;
    logic [31:0] redir_pc;
    logic [1:0]  unused_redirect_lsb;

    assign unused_redirect_lsb = redirect_pc[1:0];
    assign redir_pc = {redirect_pc[31:2], 2'b00};
    assign resp     = valid_q & cpu_req_ready;
    assign pop      = (occ_q != '0) & id_ready;
    assign push     = resp & (state_q == FETCH) & ~redirect_valid;

    // A new request may only issue if its response is guaranteed a slot.
    assign occ_d   = redirect_valid ? '0 : occ_q + CW'(push) - CW'(pop);
    assign slot_ok = (occ_d <= CW'(BUF_DEPTH - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        tgt_d   = tgt_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
                valid_d = 1'b1;
                if (redirect_valid) addr_d = redir_pc;
            end
            FETCH: begin
                if (valid_q && !cpu_req_ready) begin
                    // The cache has latched addr_q; keep it and drop the response later.
                    if (redirect_valid) begin
                        state_d = DISCARD;
                        tgt_d   = redir_pc;
                    end
                end else begin
                    if (redirect_valid) addr_d = redir_pc;
                    else if (resp)      addr_d = addr_q + 32'd4;
                    valid_d = slot_ok;
                end
            end
            DISCARD: begin
                if (redirect_valid) tgt_d = redir_pc;
                if (cpu_req_ready) begin
                    state_d = FETCH;
                    addr_d  = redirect_valid ? redir_pc : tgt_q;
                    valid_d = slot_ok;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            addr_q   <= RESET_PC;
            tgt_q    <= RESET_PC;
            valid_q  <= 1'b0;
            occ_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            occ_q   <= occ_d;
            if (redirect_valid) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) begin
                    pc_mem_q[wr_ptr_q]   <= addr_q;
                    inst_mem_q[wr_ptr_q] <= cpu_req_data;
                    wr_ptr_q             <= wr_ptr_q + PW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    assign cpu_req_addr  = addr_q;
    assign cpu_req_valid = valid_q;
    assign id_valid      = (occ_q != '0);
    assign id_pc         = pc_mem_q[rd_ptr_q];
    assign id_inst       = inst_mem_q[rd_ptr_q];
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cpu_req_addr, cpu_req_data, redirect_pc, id_pc, id_inst;
    logic        cpu_req_valid, cpu_req_ready, redirect_valid, id_valid, id_ready;
    logic [31:0] d2_addr, d2_id_pc, d2_id_inst;
    logic        d2_valid, d2_id_valid;

    int          vectors = 0;
    int          miscompares = 0;
    logic [63:0] sb_q[$];
    logic [63:0] head;
    logic [31:0] exp_pc, w2;

    always #5 clk = ~clk;

    if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) u_dut (
        .clk(clk), .rst(rst),
        .cpu_req_addr(cpu_req_addr), .cpu_req_valid(cpu_req_valid),
        .cpu_req_data(cpu_req_data), .cpu_req_ready(cpu_req_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_ready(id_ready)
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .BUF_DEPTH(2)) u_dut_wrap (
        .clk(clk), .rst(rst),
        .cpu_req_addr(d2_addr), .cpu_req_valid(d2_valid),
        .cpu_req_data(cpu_req_data), .cpu_req_ready(cpu_req_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(d2_id_valid), .id_pc(d2_id_pc), .id_inst(d2_id_inst), .id_ready(id_ready)
    );

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: pop/compare head, record expected push, apply flush, then advance.
    task automatic drive(input logic rdy, input logic idr, input logic rv,
                         input logic [31:0] rpc, input logic exp_push);
        cpu_req_ready  = rdy;
        id_ready       = idr;
        redirect_valid = rv;
        redirect_pc    = rpc;
        cpu_req_data   = inst_of(cpu_req_addr);
        if (id_valid && idr) begin
            vectors++;
            assert (sb_q.size() > 0) else begin
                miscompares++;
                $error("FAIL sb_underflow observed_pc=%h expected=no_entry", id_pc);
            end
            if (sb_q.size() > 0) begin
                head = sb_q.pop_front();
                chk("id_pc", id_pc, head[63:32]);
                chk("id_inst", id_inst, head[31:0]);
            end
        end
        if (exp_push) begin
            sb_q.push_back({exp_pc, inst_of(exp_pc)});
            exp_pc = exp_pc + 32'd4;
        end
        if (rv) sb_q.delete();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; cpu_req_ready = 1'b0; id_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0; cpu_req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", {31'd0, cpu_req_valid}, 32'd0);
        chk("rst_addr", cpu_req_addr, 32'h0);
        chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_id_pc", id_pc, 32'h0);
        chk("rst_id_inst", id_inst, 32'h0);
        chk("rst_addr_wrap", d2_addr, 32'hFFFF_FFF8);

        // Release: one IDLE cycle, then the first request.
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("first_valid", {31'd0, cpu_req_valid}, 32'd1);

        // Streaming at one per cycle; the second instance crosses the 2^32 wrap.
        exp_pc = 32'h0;
        w2     = 32'hFFFF_FFF8;
        for (int i = 0; i < 8; i++) begin
            chk("stream_addr", cpu_req_addr, exp_pc);
            chk("stream_valid", {31'd0, cpu_req_valid}, 32'd1);
            chk("wrap_addr", d2_addr, w2);
            if (i > 0) chk("stream_id_valid", {31'd0, id_valid}, 32'd1);
            w2 = w2 + 32'd4;
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        end

        // Miss at 0x20: address held for all 11 cycles, single push.
        for (int i = 0; i < 10; i++) begin
            chk("miss_addr", cpu_req_addr, 32'h20);
            chk("miss_valid", {31'd0, cpu_req_valid}, 32'd1);
            drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        end
        chk("miss_addr_last", cpu_req_addr, 32'h20);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);

        // Backpressure: buffer fills, request stops with pc held.
        chk("bp_addr", cpu_req_addr, 32'h24);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("bp_stall_valid", {31'd0, cpu_req_valid}, 32'd0);
            chk("bp_stall_addr", cpu_req_addr, 32'h28);
            chk("bp_head_pc", id_pc, 32'h20);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        end
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("bp_resume_valid", {31'd0, cpu_req_valid}, 32'd1);
        chk("bp_resume_addr", cpu_req_addr, 32'h28);
        for (int i = 0; i < 6; i++) begin
            chk("run_addr", cpu_req_addr, exp_pc);
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        end

        // Redirect while 0x40 is stalled; second redirect in DISCARD wins.
        chk("pre_redir_addr", cpu_req_addr, 32'h40);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b0);
        chk("disc_addr", cpu_req_addr, 32'h40);
        chk("disc_valid", {31'd0, cpu_req_valid}, 32'd1);
        chk("disc_id_valid", {31'd0, id_valid}, 32'd0);
        drive(1'b0, 1'b1, 1'b1, 32'h0000_1000, 1'b0);
        chk("disc_addr2", cpu_req_addr, 32'h40);
        chk("disc_id_valid2", {31'd0, id_valid}, 32'd0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("disc_id_valid3", {31'd0, id_valid}, 32'd0);
        chk("redir_target", cpu_req_addr, 32'h1000);
        chk("redir_valid", {31'd0, cpu_req_valid}, 32'd1);
        exp_pc = 32'h1000;
        for (int i = 0; i < 4; i++) begin
            chk("tgt_addr", cpu_req_addr, exp_pc);
            drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        end

        // Redirect in the same cycle as ready: response dropped, no DISCARD.
        chk("same_pre_addr", cpu_req_addr, 32'h1010);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0200, 1'b0);
        chk("same_id_valid", {31'd0, id_valid}, 32'd0);
        chk("same_addr", cpu_req_addr, 32'h200);
        chk("same_valid", {31'd0, cpu_req_valid}, 32'd1);
        exp_pc = 32'h200;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        chk("unalign_pre", cpu_req_addr, 32'h204);
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0203, 1'b0);
        chk("unalign_addr", cpu_req_addr, 32'h200);
        chk("unalign_id_valid", {31'd0, id_valid}, 32'd0);
        exp_pc = 32'h200;
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("drain_id_valid", {31'd0, id_valid}, 32'd0);
        chk("drain_addr", cpu_req_addr, 32'h208);

        // Reset with a request pending.
        rst = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("mid_rst_valid", {31'd0, cpu_req_valid}, 32'd0);
        chk("mid_rst_addr", cpu_req_addr, 32'h0);
        chk("mid_rst_id_valid", {31'd0, id_valid}, 32'd0);
        chk("mid_rst_id_pc", id_pc, 32'h0);
        chk("mid_rst_id_inst", id_inst, 32'h0);
        chk("mid_rst_addr_wrap", d2_addr, 32'hFFFF_FFF8);
        rst = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction-fetch front end that sits directly upstream of the instruction cache. It owns the PC and issues one-outstanding-request fetches on the cache's CPU-side valid/ready port. Returned instructions are queued in a small {pc, inst} buffer for the decode stage. Branch/jump redirects from later stages flush the buffer and cleanly drop any in-flight fetch.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- BUF_DEPTH, 2, fetch buffer entries (power of two, ≥2)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low
- cpu_req_addr  out  32  fetch address to I-cache
- cpu_req_valid  out  1  fetch request valid
- cpu_req_data  in  32  instruction from I-cache, valid in cycle cpu_req_ready=1
- cpu_req_ready  in  1  I-cache completes current request this cycle
- redirect_valid  in  1  control-flow redirect from EX
- redirect_pc  in  32  redirect target; bits [1:0] ignored (treated as 0)
- id_valid  out  1  buffer head valid to decode
- id_pc  out  32  PC of head entry
- id_inst  out  32  instruction of head entry
- id_ready  in  1  decode accepts head this cycle

## Operation
- States: IDLE, FETCH, DISCARD.
- IDLE: entered only from reset. Next edge with rst=1 → FETCH with cpu_req_addr=pc.
- FETCH: cpu_req_valid=1. cpu_req_addr is held stable until cpu_req_ready=1; the cache latches the address on entry to tag compare, so the address must never change mid-request.
  - On the ready cycle, {cpu_req_addr, cpu_req_data} is pushed to the buffer and pc ← pc+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - Next request issues the following cycle only if buffer occupancy after that edge ≤ BUF_DEPTH-1, so every outstanding request has a reserved slot. Otherwise cpu_req_valid drops to 0 and re-asserts the first cycle a slot is reserved.
- Redirect with a request pending (cpu_req_valid=1, cpu_req_ready=0):
  - Buffer is flushed and pc ← {redirect_pc[31:2],2'b00}.
  - State → DISCARD; the old request stays asserted with its old address.
- DISCARD: cpu_req_valid=1, old address held. On cpu_req_ready=1 the response is dropped (no push) and state → FETCH at the redirect pc next cycle.
  - A further redirect in DISCARD overwrites the target; latest wins.
- Redirect with no request pending, or in the same cycle as cpu_req_ready=1:
  - Response dropped, buffer flushed.
  - Next cycle FETCH issues at the redirect pc; no DISCARD.
- Buffer:
  - id_valid = occupancy≠0; id_pc/id_inst = head entry.
  - Pop when id_valid & id_ready. Push and pop may occur in the same cycle, including at full.
  - Redirect flush overrides a same-cycle push/pop; id_valid=0 the next cycle.
- Reset mid-operation (rst=0 at any edge): all state cleared regardless of pending handshake. The I-cache shares the reset, so no request is orphaned.

## Timing
- Reset values: cpu_req_valid=0, cpu_req_addr=RESET_PC, id_valid=0, id_pc=0, id_inst=0, occupancy=0, state IDLE.
- All outputs are registered except id_pc/id_inst/id_valid, which are driven directly from buffer registers (no combinational path from inputs).
- First request: cpu_req_valid=1 in the 2nd cycle after rst rises (IDLE for 1 cycle).
- Fetch-to-decode latency: ready cycle N → id_valid=1 in cycle N+1.
- With ready held high and decode always ready, throughput is 1 instruction/cycle, with back-to-back requests at consecutive PCs.
- Redirect → first request at target: next cycle if no request pending or same-cycle completion. Otherwise, the cycle after the discarded response.

## Test plan
- Reset release, ready tied 1, id_ready=1 → requests 0x0,0x4,0x8… on consecutive cycles. id_pc follows one cycle later with matching id_inst.
- Cache miss: ready low for 10 cycles at 0x20 → cpu_req_addr stays 0x20 for all 11 cycles. A single entry {0x20, data} is pushed.
- Backpressure: id_ready=0, BUF_DEPTH=2 → after 2 entries cpu_req_valid=0 and pc holds 0x8. Raising id_ready resumes at 0x8 with no lost or duplicated entries.
- Redirect to 0x1000 while request 0x40 is stalled → cpu_req_addr stays 0x40 until ready, and that response is not pushed. Next request is 0x1000; buffer empty meanwhile.
- Redirect to 0x200 in the same cycle as ready for 0x10 and id_ready=1 → 0x10 is not pushed, id_valid=0 next cycle, next request 0x200. Also drive redirect_pc=0x203 → request 0x200.
- RESET_PC=32'hFFFF_FFF8 → requests FFFF_FFF8, FFFF_FFFC, 0000_0000. Assert rst=0 mid-request → all outputs at reset values next cycle.
